// File: rtl/ir_pkg.sv
// Shared types and defaults for the IR trip conditioner (24 MHz sysclk domain).
package ir_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } ir_state_t;

    localparam int unsigned SYSCLK_HZ      = 24_000_000;
    // Lockout of 10 ms, stall after 1 s of silence.
    localparam int unsigned DEF_MIN_PERIOD = SYSCLK_HZ / 100;
    localparam int unsigned DEF_MAX_PERIOD = SYSCLK_HZ;
    localparam int unsigned REJECT_W       = 8;

endpackage

// File: rtl/ir_glitch_filter.sv
// Synchroniser, stable-count glitch filter and rising-edge detector for the raw IR input.
module ir_glitch_filter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic ir_raw,
    output logic edge_out
);
    import ir_pkg::*;

    localparam int unsigned     FCW   = $clog2(FILTER_CYCLES + 1);
    localparam logic [FCW-1:0] FLAST = FCW'(FILTER_CYCLES - 1);
    localparam logic [FCW-1:0] FONE  = FCW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q;
    logic [FCW-1:0]         fcnt_q, fcnt_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Counter runs only while the synchronised level disagrees with the filtered one.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_lvl != filt_q) begin
            if (fcnt_q == FLAST) begin
                filt_d = sync_lvl;
            end else begin
                fcnt_d = fcnt_q + FONE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_q      <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], ir_raw};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
        end
    end

    assign edge_out = filt_q & ~filt_prev_q;

endmodule

// File: rtl/ir_trip_conditioner.sv
// IR break-beam conditioner: trip pulse, revolution period, lock/stall flags.
// Define IR_PERIOD_AVG_EN to report the mean of the last four periods instead of the raw one.
module ir_trip_conditioner
    import ir_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned MIN_PERIOD    = DEF_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD    = DEF_MAX_PERIOD,
    parameter int unsigned PERIOD_W      = 25
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                ir_raw,
    output logic                trip_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                stalled,
    output logic [REJECT_W-1:0] reject_count,
    output ir_state_t           state_dbg
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);
    localparam logic [REJECT_W-1:0] ONE_R = REJECT_W'(1);

    logic                edge_w;
    ir_state_t           state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [REJECT_W-1:0] reject_q, reject_d;
    logic                trip_q, trip_d;
    logic                pv_q, pv_d;
    logic                locked_q, locked_d;
    logic                stalled_q, stalled_d;
    logic                restart, meas_ok;

    ir_glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .ir_raw  (ir_raw),
        .edge_out(edge_w)
    );

    // restart: trip that (re)starts measurement; meas_ok: trip that closes a valid period.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        trip_d   = 1'b0;
        reject_d = reject_q;
        restart  = 1'b0;
        meas_ok  = 1'b0;
        if ((state_q == ACQUIRE || state_q == LOCKED) && cnt_q != MAX_P) begin
            cnt_d = cnt_q + ONE_P;
        end
        case (state_q)
            IDLE, STALLED: begin
                if (edge_w) restart = 1'b1;
            end
            ACQUIRE, LOCKED: begin
                if (edge_w && cnt_q == MAX_P) begin
                    restart = 1'b1;
                end else if (edge_w && cnt_q < MIN_P) begin
                    if (reject_q != '1) reject_d = reject_q + ONE_R;
                end else if (edge_w) begin
                    meas_ok = 1'b1;
                end else if (cnt_q == MAX_P) begin
                    state_d = STALLED;
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            trip_d  = 1'b1;
            cnt_d   = ONE_P;
            state_d = ACQUIRE;
        end
        if (meas_ok) begin
            trip_d  = 1'b1;
            cnt_d   = ONE_P;
            state_d = LOCKED;
        end
        stalled_d = (state_d == STALLED);
    end

`ifdef IR_PERIOD_AVG_EN
    logic [3:0][PERIOD_W-1:0] hist_q, hist_d;
    logic [2:0]               hist_n_q, hist_n_d;
    logic [PERIOD_W+1:0]      hist_sum;
    logic                     hist_full;

    always_comb begin
        hist_d   = hist_q;
        hist_n_d = hist_n_q;
        if (restart) begin
            hist_d   = '0;
            hist_n_d = '0;
        end
        if (meas_ok) begin
            hist_d = {hist_q[2:0], cnt_q};
            if (hist_n_q != 3'd4) hist_n_d = hist_n_q + 3'd1;
        end
        hist_sum  = {2'b00, hist_d[0]} + {2'b00, hist_d[1]}
                  + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
        hist_full = (hist_n_d == 3'd4);
        pv_d      = meas_ok & hist_full;
        period_d  = pv_d ? hist_sum[PERIOD_W+1:2] : period_q;
        locked_d  = (state_d == LOCKED) && hist_full;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hist_q   <= '0;
            hist_n_q <= '0;
        end else begin
            hist_q   <= hist_d;
            hist_n_q <= hist_n_d;
        end
    end
`else
    always_comb begin
        pv_d     = meas_ok;
        period_d = meas_ok ? cnt_q : period_q;
        locked_d = (state_d == LOCKED);
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            reject_q  <= '0;
            trip_q    <= 1'b0;
            pv_q      <= 1'b0;
            locked_q  <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            reject_q  <= reject_d;
            trip_q    <= trip_d;
            pv_q      <= pv_d;
            locked_q  <= locked_d;
            stalled_q <= stalled_d;
        end
    end

    assign trip_pulse   = trip_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign stalled      = stalled_q;
    assign reject_count = reject_q;
    assign state_dbg    = state_q;

endmodule
